// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI responder: FSM states, frame lengths,
// SCK edge-role decode and TX bit selection.
package spi_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_t;

    localparam int FRAME_LEN_8  = 8;
    localparam int FRAME_LEN_16 = 16;

    typedef struct packed {
        logic sample;
        logic shift;
    } edge_role_t;

    // Leading edge leaves the CPOL idle level, trailing edge returns to it.
    function automatic edge_role_t edge_roles(input logic cpol, input logic cpha,
                                              input logic sck_rise, input logic sck_fall);
        edge_role_t r;
        logic leading;
        logic trailing;
        leading  = cpol ? sck_fall : sck_rise;
        trailing = cpol ? sck_rise : sck_fall;
        r.sample = cpha ? trailing : leading;
        r.shift  = cpha ? leading : trailing;
        return r;
    endfunction

    function automatic logic [3:0] last_bit_idx(input logic dff);
        return dff ? 4'(FRAME_LEN_16 - 1) : 4'(FRAME_LEN_8 - 1);
    endfunction

    function automatic logic tx_bit(input logic [15:0] sh, input logic dff, input logic lsb);
        if (lsb) begin
            return sh[0];
        end
        return dff ? sh[15] : sh[7];
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-stage synchroniser for one SPI pin with rise/fall detect taken from the
// last stage against one extra flop.
module spi_pin_sync
    import spi_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {SYNC_STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], pin};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign level = chain[SYNC_STAGES-1];
    assign rise  = chain[SYNC_STAGES-1] & ~prev;
    assign fall  = ~chain[SYNC_STAGES-1] & prev;

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI responder core: all pins oversampled on clk, single-entry TX buffer,
// single-entry RX holding register, OVR/UDR reporting, CPOL/CPHA modes 0-3.
//
//   state     | meaning
//   ST_IDLE   | CS high, MISO tri-stated, waiting for CS falling edge
//   ST_ACTIVE | CS low, shifting frames with mode latched at CS assertion
module spi_slave_ctrl
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        CPOL,
    input  logic        CPHA,
    input  logic        DFF,
    input  logic        LSBFIRST,
    input  logic [15:0] i_TX_Word,
    input  logic        i_TX_Valid,
    output logic        o_TX_Ready,
    output logic [15:0] o_RX_Word,
    output logic        o_RX_Valid,
    input  logic        i_RX_Ready,
    output logic        o_OVR,
    output logic        o_UDR,
    input  logic        i_clr_err,
    output logic        o_BSY,
    input  logic        i_SPI_SCK,
    input  logic        i_SPI_MOSI,
    input  logic        i_SPI_CS,
    output logic        o_SPI_MISO,
    output logic        o_SPI_MISO_OE
);

    logic sck_s, sck_rise, sck_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic cs_s, cs_rise, cs_fall;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk(clk), .rst_n(rst_n), .pin(i_SPI_SCK),
        .level(sck_s), .rise(sck_rise), .fall(sck_fall)
    );
    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .pin(i_SPI_MOSI),
        .level(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
    );
    // CS resets deasserted so reset release cannot fake a falling edge.
    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .pin(i_SPI_CS),
        .level(cs_s), .rise(cs_rise), .fall(cs_fall)
    );

    logic unused_pin_edges;
    assign unused_pin_edges = ^{sck_s, mosi_rise, mosi_fall, cs_rise};

    spi_state_t  state;
    logic [3:0]  bit_cnt;
    logic        cpol_q, cpha_q, dff_q, lsb_q;
    logic [15:0] tx_buf;
    logic        tx_full;
    logic [15:0] tx_shift;
    logic [15:0] rx_shift;
    logic        frame_done;

    edge_role_t  role;
    logic        in_active, sample_ev, shift_ev, load_ev, advance_ev, tx_wr;
    logic [15:0] tx_next, rx_base, rx_next;
    logic        ovr_set;

    always_comb begin
        role       = edge_roles(cpol_q, cpha_q, sck_rise, sck_fall);
        in_active  = (state == ST_ACTIVE) && !cs_s;
        sample_ev  = in_active && role.sample;
        shift_ev   = in_active && role.shift;
        // bit_cnt is 0 both before the first CPHA=1 leading edge and after the
        // last CPHA=0 sample, so one condition covers both LOAD points.
        load_ev    = ((state == ST_IDLE) && cs_fall && !CPHA) || (shift_ev && (bit_cnt == 4'd0));
        advance_ev = shift_ev && (bit_cnt != 4'd0);
        tx_wr      = i_TX_Valid && !tx_full;

        tx_next = tx_shift;
        if (load_ev) begin
            tx_next = tx_full ? tx_buf : 16'h0000;
        end else if (advance_ev) begin
            tx_next = lsb_q ? (tx_shift >> 1) : (tx_shift << 1);
        end

        rx_base = (bit_cnt == 4'd0) ? 16'h0000 : rx_shift;
        if (!lsb_q) begin
            rx_next = {rx_base[14:0], mosi_s};
        end else if (dff_q) begin
            rx_next = {mosi_s, rx_base[15:1]};
        end else begin
            rx_next = {8'h00, mosi_s, rx_base[7:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            bit_cnt       <= 4'd0;
            cpol_q        <= 1'b0;
            cpha_q        <= 1'b0;
            dff_q         <= 1'b0;
            lsb_q         <= 1'b0;
            tx_buf        <= 16'h0000;
            tx_full       <= 1'b0;
            tx_shift      <= 16'h0000;
            rx_shift      <= 16'h0000;
            frame_done    <= 1'b0;
            o_UDR         <= 1'b0;
            o_SPI_MISO    <= 1'b0;
            o_SPI_MISO_OE <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            o_UDR      <= load_ev && !tx_full;
            tx_shift   <= tx_next;

            // A write landing on a LOAD cycle is not seen by that LOAD.
            if (load_ev && tx_full) begin
                tx_full <= 1'b0;
            end else if (tx_wr) begin
                tx_full <= 1'b1;
                tx_buf  <= i_TX_Word;
            end

            case (state)
                ST_IDLE: begin
                    o_SPI_MISO_OE <= 1'b0;
                    o_SPI_MISO    <= 1'b0;
                    if (cs_fall) begin
                        state         <= ST_ACTIVE;
                        bit_cnt       <= 4'd0;
                        cpol_q        <= CPOL;
                        cpha_q        <= CPHA;
                        dff_q         <= DFF;
                        lsb_q         <= LSBFIRST;
                        o_SPI_MISO_OE <= 1'b1;
                        o_SPI_MISO    <= tx_bit(tx_next, DFF, LSBFIRST);
                    end
                end
                ST_ACTIVE: begin
                    if (cs_s) begin
                        state         <= ST_IDLE;
                        bit_cnt       <= 4'd0;
                        tx_shift      <= 16'h0000;
                        o_SPI_MISO_OE <= 1'b0;
                        o_SPI_MISO    <= 1'b0;
                    end else begin
                        o_SPI_MISO <= tx_bit(tx_next, dff_q, lsb_q);
                        if (sample_ev) begin
                            rx_shift <= rx_next;
                            if (bit_cnt == last_bit_idx(dff_q)) begin
                                bit_cnt    <= 4'd0;
                                frame_done <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign ovr_set = frame_done && o_RX_Valid && !i_RX_Ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_RX_Word  <= 16'h0000;
            o_RX_Valid <= 1'b0;
            o_OVR      <= 1'b0;
        end else begin
            if (frame_done && !ovr_set) begin
                o_RX_Word  <= rx_shift;
                o_RX_Valid <= 1'b1;
            end else if (o_RX_Valid && i_RX_Ready) begin
                o_RX_Valid <= 1'b0;
            end
            o_OVR <= ovr_set | (o_OVR & ~i_clr_err);
        end
    end

    assign o_TX_Ready = ~tx_full;
    assign o_BSY      = ~cs_s;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed bench for spi_slave_ctrl: the bench plays the SPI master and
// compares MISO data, RX words, flags and completion latency against a table.
module tb_spi_slave_ctrl;

    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        CPOL = 1'b0, CPHA = 1'b0, DFF = 1'b0, LSBFIRST = 1'b0;
    logic [15:0] i_TX_Word = 16'h0000;
    logic        i_TX_Valid = 1'b0;
    logic        o_TX_Ready;
    logic [15:0] o_RX_Word;
    logic        o_RX_Valid;
    logic        i_RX_Ready = 1'b0;
    logic        o_OVR, o_UDR;
    logic        i_clr_err = 1'b0;
    logic        o_BSY;
    logic        i_SPI_SCK = 1'b0, i_SPI_MOSI = 1'b0, i_SPI_CS = 1'b1;
    logic        o_SPI_MISO, o_SPI_MISO_OE;

    spi_slave_ctrl #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .clk(clk), .rst_n(rst_n),
        .CPOL(CPOL), .CPHA(CPHA), .DFF(DFF), .LSBFIRST(LSBFIRST),
        .i_TX_Word(i_TX_Word), .i_TX_Valid(i_TX_Valid), .o_TX_Ready(o_TX_Ready),
        .o_RX_Word(o_RX_Word), .o_RX_Valid(o_RX_Valid), .i_RX_Ready(i_RX_Ready),
        .o_OVR(o_OVR), .o_UDR(o_UDR), .i_clr_err(i_clr_err), .o_BSY(o_BSY),
        .i_SPI_SCK(i_SPI_SCK), .i_SPI_MOSI(i_SPI_MOSI), .i_SPI_CS(i_SPI_CS),
        .o_SPI_MISO(o_SPI_MISO), .o_SPI_MISO_OE(o_SPI_MISO_OE)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_sample_cyc = 0;
    int rxv_rise_cyc = 0;
    int udr_cnt = 0;
    logic rxv_prev = 1'b0;
    logic [15:0] acc_q[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (o_UDR) udr_cnt++;
        if (o_RX_Valid && !rxv_prev) rxv_rise_cyc = cyc;
        if (o_RX_Valid && i_RX_Ready) acc_q.push_back(o_RX_Word);
        rxv_prev = o_RX_Valid;
    end

    typedef struct {
        logic        cpol, cpha, dff, lsb;
        logic [15:0] tx, mosi, exp_miso, exp_rx;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_tx(input logic [15:0] w);
        i_TX_Word  = w;
        i_TX_Valid = 1'b1;
        tick(1);
        i_TX_Valid = 1'b0;
    endtask

    task automatic consume();
        i_RX_Ready = 1'b1;
        tick(1);
        i_RX_Ready = 1'b0;
    endtask

    task automatic wait_rx(input string name);
        int n;
        n = 0;
        while (!o_RX_Valid && n < 50) begin
            tick(1);
            n++;
        end
        check(name, o_RX_Valid, 1);
    endtask

    task automatic cs_start(input logic cpol, input logic cpha, input logic dff, input logic lsb);
        CPOL = cpol; CPHA = cpha; DFF = dff; LSBFIRST = lsb;
        i_SPI_SCK = cpol;
        tick(4);
        i_SPI_CS = 1'b0;
        tick(HALF);
    endtask

    task automatic cs_end();
        tick(HALF);
        i_SPI_CS = 1'b1;
        tick(HALF);
    endtask

    // Master side: nb bits of mo out on MOSI, MISO captured on each sample edge.
    task automatic xfer(input logic cpol, input logic cpha, input logic dff, input logic lsb,
                        input logic [15:0] mo, input int nb, output logic [15:0] mi);
        int n;
        int idx;
        n  = dff ? 16 : 8;
        mi = 16'h0000;
        for (int i = 0; i < nb && i < n; i++) begin
            idx = lsb ? i : n - 1 - i;
            if (!cpha) begin
                i_SPI_MOSI = mo[idx];
                tick(HALF);
                mi[idx] = o_SPI_MISO;
                i_SPI_SCK = ~cpol;
                last_sample_cyc = cyc;
                tick(HALF);
                i_SPI_SCK = cpol;
            end else begin
                i_SPI_SCK  = ~cpol;
                i_SPI_MOSI = mo[idx];
                tick(HALF);
                mi[idx] = o_SPI_MISO;
                i_SPI_SCK = cpol;
                last_sample_cyc = cyc;
                tick(HALF);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_ready"}, o_TX_Ready, 1);
        check({tag, "_rx_valid"}, o_RX_Valid, 0);
        check({tag, "_rx_word"}, o_RX_Word, 0);
        check({tag, "_ovr"}, o_OVR, 0);
        check({tag, "_udr"}, o_UDR, 0);
        check({tag, "_bsy"}, o_BSY, 0);
        check({tag, "_miso"}, o_SPI_MISO, 0);
        check({tag, "_miso_oe"}, o_SPI_MISO_OE, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] mi, m1, m2, w0, w1;
        int u0, n;

        //          cpol  cpha  dff   lsb   tx        mosi      exp_miso  exp_rx
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'hFFA5, 16'h003C, 16'h00A5, 16'h003C};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h1234, 16'hBEEF, 16'h1234, 16'hBEEF};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h005A, 16'h12C3, 16'h005A, 16'h00C3};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h8001, 16'h7FFE, 16'h8001, 16'h7FFE};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'hF00F, 16'h0FF1, 16'hF00F, 16'h0FF1};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0096, 16'h0069, 16'h0096, 16'h0069};

        tick(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick(3);

        for (int i = 0; i < 6; i++) begin
            check($sformatf("v%0d_tx_ready_pre", i), o_TX_Ready, 1);
            write_tx(vecs[i].tx);
            check($sformatf("v%0d_tx_ready_full", i), o_TX_Ready, 0);
            cs_start(vecs[i].cpol, vecs[i].cpha, vecs[i].dff, vecs[i].lsb);
            check($sformatf("v%0d_bsy", i), o_BSY, 1);
            check($sformatf("v%0d_miso_oe", i), o_SPI_MISO_OE, 1);
            xfer(vecs[i].cpol, vecs[i].cpha, vecs[i].dff, vecs[i].lsb, vecs[i].mosi, 16, mi);
            cs_end();
            wait_rx($sformatf("v%0d_rx_valid", i));
            check($sformatf("v%0d_miso_word", i), mi, vecs[i].exp_miso);
            check($sformatf("v%0d_rx_word", i), o_RX_Word, vecs[i].exp_rx);
            check($sformatf("v%0d_latency", i), rxv_rise_cyc - last_sample_cyc, SYNC_STAGES + 2);
            check($sformatf("v%0d_tx_ready_post", i), o_TX_Ready, 1);
            consume();
        end

        // Mode 1 back-to-back frames, second TX word written mid-frame; mode
        // inputs change after CS assertion and must not take effect.
        acc_q.delete();
        u0 = udr_cnt;
        i_RX_Ready = 1'b1;
        write_tx(16'h0011);
        cs_start(1'b0, 1'b1, 1'b0, 1'b0);
        LSBFIRST = 1'b1;
        DFF = 1'b1;
        fork
            xfer(1'b0, 1'b1, 1'b0, 1'b0, 16'h005A, 16, m1);
            begin
                tick(40);
                write_tx(16'h0022);
            end
        join
        xfer(1'b0, 1'b1, 1'b0, 1'b0, 16'h00C3, 16, m2);
        cs_end();
        tick(10);
        i_RX_Ready = 1'b0;
        LSBFIRST = 1'b0;
        DFF = 1'b0;
        w0 = (acc_q.size() > 0) ? acc_q[0] : 16'hDEAD;
        w1 = (acc_q.size() > 1) ? acc_q[1] : 16'hDEAD;
        check("b2b_miso_1", m1, 16'h0011);
        check("b2b_miso_2", m2, 16'h0022);
        check("b2b_rx_count", acc_q.size(), 2);
        check("b2b_rx_1", w0, 16'h005A);
        check("b2b_rx_2", w1, 16'h00C3);
        check("b2b_no_udr", udr_cnt - u0, 0);

        // Mode 2 with an empty TX buffer: LOAD at CS assertion underruns.
        CPOL = 1'b1; CPHA = 1'b0; DFF = 1'b0; LSBFIRST = 1'b0;
        i_SPI_SCK = 1'b1;
        tick(4);
        i_SPI_CS = 1'b0;
        n = 0;
        while (!o_UDR && n < 10) begin
            tick(1);
            n++;
        end
        check("udr_pulse", o_UDR, 1);
        tick(1);
        check("udr_one_cycle", o_UDR, 0);
        tick(HALF);
        xfer(1'b1, 1'b0, 1'b0, 1'b0, 16'h00E7, 16, mi);
        cs_end();
        wait_rx("udr_rx_valid");
        check("udr_miso_zero", mi, 16'h0000);
        check("udr_rx_word", o_RX_Word, 16'h00E7);
        consume();

        // Overrun: second frame completes while the first is unread.
        cs_start(1'b0, 1'b0, 1'b0, 1'b0);
        xfer(1'b0, 1'b0, 1'b0, 1'b0, 16'h0055, 16, mi);
        cs_end();
        wait_rx("ovr_rx1_valid");
        check("ovr_clear_after_first", o_OVR, 0);
        cs_start(1'b0, 1'b0, 1'b0, 1'b0);
        xfer(1'b0, 1'b0, 1'b0, 1'b0, 16'h00AA, 16, mi);
        cs_end();
        tick(10);
        check("ovr_set", o_OVR, 1);
        check("ovr_word_kept", o_RX_Word, 16'h0055);
        check("ovr_valid_kept", o_RX_Valid, 1);
        i_clr_err = 1'b1;
        tick(1);
        i_clr_err = 1'b0;
        check("ovr_cleared", o_OVR, 0);
        consume();
        check("ovr_consumed", o_RX_Valid, 0);

        // Abort after 4 bits, then a clean frame.
        cs_start(1'b0, 1'b0, 1'b0, 1'b0);
        xfer(1'b0, 1'b0, 1'b0, 1'b0, 16'h00F0, 4, mi);
        cs_end();
        tick(10);
        check("abort_no_rx", o_RX_Valid, 0);
        check("abort_bsy", o_BSY, 0);
        cs_start(1'b0, 1'b0, 1'b0, 1'b0);
        xfer(1'b0, 1'b0, 1'b0, 1'b0, 16'h0081, 16, mi);
        cs_end();
        wait_rx("abort_next_valid");
        check("abort_next_word", o_RX_Word, 16'h0081);

        // Reset mid-frame with RX full and TX buffer full.
        cs_start(1'b0, 1'b0, 1'b0, 1'b0);
        write_tx(16'h003C);
        xfer(1'b0, 1'b0, 1'b0, 1'b0, 16'h00FF, 3, mi);
        check("pre_rst_tx_ready", o_TX_Ready, 0);
        check("pre_rst_bsy", o_BSY, 1);
        check("pre_rst_rx_valid", o_RX_Valid, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        i_SPI_CS = 1'b1;
        i_SPI_SCK = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
